decode_ctrl_stage: RTL and testbench

//  Registered decode/control stage: takes a fetched 32-bit RV32I(+M) instruction, produces ALU/writeback/PC

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/instr_decode.sv | 133 +++++++++++++
 rtl/decode_ctrl_stage.sv | 117 +++++++++++
 tb/tb_decode_ctrl_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode/control types for the decode stage: opcodes, control encodings
// and the packed control word handed to execute.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_ADD   = 4'd3,
    ALU_SUB   = 4'd4,
    ALU_MUL   = 4'd5,
    ALU_MULH  = 4'd6,
    ALU_MULHU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd12,
    ALU_SLTU  = 4'd13
  } aluop_e;

  typedef enum logic [1:0] {
    RS_GPIO = 2'd0,
    RS_IMMU = 2'd1,
    RS_ALU  = 2'd2,
    RS_PC4  = 2'd3
  } regsel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pcsrc_e;

  typedef struct packed {
    logic    alusrc;
    logic    regwrite;
    regsel_e regsel;
    aluop_e  aluop;
    pcsrc_e  pcsrc_ex;
    logic    gpio_we;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic is_mul(input aluop_e op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure combinational RV32I(+M subset) decoder: instruction word -> control word.
// Any encoding not recognised collapses to a control word with only illegal set.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter bit          ENABLE_M = 1'b1,
  parameter logic [11:0] CSR_GPIO = 12'h7C0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal;
  ctrl_t      w_ctrl;

  assign w_op = instr[6:0];
  assign w_f3 = instr[14:12];
  assign w_f7 = instr[31:25];

  always_comb begin
    w_ctrl  = CTRL_NOP;
    w_legal = 1'b0;
    case (w_op)
      OP_R: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_ALU;
        w_legal         = 1'b1;
        case (w_f7)
          7'b0000000: begin
            case (w_f3)
              3'b000:  w_ctrl.aluop = ALU_ADD;
              3'b001:  w_ctrl.aluop = ALU_SLL;
              3'b010:  w_ctrl.aluop = ALU_SLT;
              3'b011:  w_ctrl.aluop = ALU_SLTU;
              3'b100:  w_ctrl.aluop = ALU_XOR;
              3'b101:  w_ctrl.aluop = ALU_SRL;
              3'b110:  w_ctrl.aluop = ALU_OR;
              default: w_ctrl.aluop = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (w_f3)
              3'b000:  w_ctrl.aluop = ALU_SUB;
              3'b101:  w_ctrl.aluop = ALU_SRA;
              default: w_legal = 1'b0;
            endcase
          end
          7'b0000001: begin
            case (w_f3)
              3'b000:  w_ctrl.aluop = ALU_MUL;
              3'b001:  w_ctrl.aluop = ALU_MULH;
              3'b011:  w_ctrl.aluop = ALU_MULHU;
              default: w_legal = 1'b0;
            endcase
            if (!ENABLE_M) w_legal = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_ALU;
        w_legal         = 1'b1;
        case (w_f3)
          3'b000:  w_ctrl.aluop = ALU_ADD;
          3'b001: begin
            w_ctrl.aluop = ALU_SLL;
            w_legal      = (w_f7 == 7'b0000000);
          end
          3'b010:  w_ctrl.aluop = ALU_SLT;
          3'b011:  w_ctrl.aluop = ALU_SLTU;
          3'b100:  w_ctrl.aluop = ALU_XOR;
          3'b101: begin
            // instr[30] picks arithmetic vs logical; the rest of funct7 must be zero.
            w_ctrl.aluop = instr[30] ? ALU_SRA : ALU_SRL;
            w_legal      = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          3'b110:  w_ctrl.aluop = ALU_OR;
          default: w_ctrl.aluop = ALU_AND;
        endcase
      end
      OP_LUI: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_IMMU;
        w_legal         = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_PC4;
        w_ctrl.pcsrc_ex = PC_JAL;
        w_legal         = 1'b1;
      end
      OP_JALR: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_PC4;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = ALU_ADD;
        w_ctrl.pcsrc_ex = PC_JALR;
        w_legal         = (w_f3 == 3'b000);
      end
      OP_BR: begin
        w_ctrl.pcsrc_ex = PC_BRANCH;
        w_legal         = 1'b1;
        case (w_f3)
          3'b000, 3'b001: w_ctrl.aluop = ALU_SUB;
          3'b100, 3'b101: w_ctrl.aluop = ALU_SLT;
          3'b110, 3'b111: w_ctrl.aluop = ALU_SLTU;
          default:        w_legal = 1'b0;
        endcase
      end
      OP_SYS: begin
        w_ctrl.gpio_we  = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = RS_GPIO;
        w_legal         = (w_f3 == 3'b001) && (instr[31:20] == CSR_GPIO);
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = w_ctrl;
    if (!w_legal) begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage between fetch and execute: one-entry control
// register with valid/ready flow control, flush, and a post-MUL intake stall.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 3,
  parameter logic [11:0] CSR_GPIO   = 12'h7C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        alusrc,
  output logic        regwrite,
  output logic [1:0]  regsel,
  output logic [3:0]  aluop,
  output logic [1:0]  pcsrc_ex,
  output logic        gpio_we,
  output logic        illegal,
  output logic        dbg_state
);

  // Handshake: a word moves on a port in any cycle where its valid and ready are
  // both high; in_ready never looks at in_valid, and out_valid/controls only change
  // on an output transfer, an accept, a flush or reset.
  typedef enum logic {ST_RUN = 1'b0, ST_MULWAIT = 1'b1} state_e;

  localparam logic [3:0] STALL_LOAD = 4'(MUL_CYCLES - 1);

  state_e     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_valid;
  ctrl_t      r_ctrl;
  ctrl_t      w_dec;
  logic       w_accept;
  logic       w_xfer;

  instr_decode #(
    .ENABLE_M (ENABLE_M),
    .CSR_GPIO (CSR_GPIO)
  ) u_decode (
    .instr (instr),
    .ctrl  (w_dec)
  );

  assign in_ready = (r_state == ST_RUN) && (!r_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_xfer && is_mul(r_ctrl.aluop) && (MUL_CYCLES > 1)) begin
            w_state_nxt = ST_MULWAIT;
            w_cnt_nxt   = STALL_LOAD;
          end
        end
        default: begin
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_dec;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
    end
  end

  assign out_valid = r_valid;
  assign alusrc    = r_ctrl.alusrc;
  assign regwrite  = r_ctrl.regwrite;
  assign regsel    = r_ctrl.regsel;
  assign aluop     = r_ctrl.aluop;
  assign pcsrc_ex  = r_ctrl.pcsrc_ex;
  assign gpio_we   = r_ctrl.gpio_we;
  assign illegal   = r_ctrl.illegal;
  assign dbg_state = (r_state == ST_MULWAIT);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios plus a randomized run scored
// against a table-driven decode model and a one-entry expected queue.
module tb_decode_ctrl_stage;

  localparam int MULC = 3;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic       in_ready, out_valid, alusrc, regwrite, gpio_we, illegal, dbg_state;
  logic [1:0] regsel, pcsrc_ex;
  logic [3:0] aluop;

  logic       m0_in_ready, m0_out_valid, m0_alusrc, m0_regwrite, m0_gpio_we, m0_illegal, m0_dbg;
  logic [1:0] m0_regsel, m0_pcsrc;
  logic [3:0] m0_aluop;

  logic [11:0] act, m0_act;
  assign act    = {alusrc, regwrite, regsel, aluop, pcsrc_ex, gpio_we, illegal};
  assign m0_act = {m0_alusrc, m0_regwrite, m0_regsel, m0_aluop, m0_pcsrc, m0_gpio_we, m0_illegal};

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  decode_ctrl_stage #(.ENABLE_M(1'b1), .MUL_CYCLES(MULC), .CSR_GPIO(12'h7C0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .alusrc(alusrc), .regwrite(regwrite), .regsel(regsel), .aluop(aluop),
    .pcsrc_ex(pcsrc_ex), .gpio_we(gpio_we), .illegal(illegal), .dbg_state(dbg_state)
  );

  decode_ctrl_stage #(.ENABLE_M(1'b0), .MUL_CYCLES(1), .CSR_GPIO(12'h7C0)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr(instr), .in_valid(in_valid),
    .in_ready(m0_in_ready), .out_valid(m0_out_valid), .out_ready(out_ready),
    .alusrc(m0_alusrc), .regwrite(m0_regwrite), .regsel(m0_regsel), .aluop(m0_aluop),
    .pcsrc_ex(m0_pcsrc), .gpio_we(m0_gpio_we), .illegal(m0_illegal), .dbg_state(m0_dbg)
  );

  always #5 clk = ~clk;

  // Reference decode tables indexed by funct3 (-1 = not a legal encoding).
  int alu_r [8] = '{3, 8, 12, 13, 2, 9, 1, 0};
  int alu_br[8] = '{4, 4, -1, -1, 12, 12, 13, 13};
  int alu_m [8] = '{5, 6, -1, 7, -1, -1, -1, -1};

  function automatic logic [11:0] pack(input bit s, input bit w, input int sel,
                                       input int alu, input int pc, input bit g);
    logic [1:0] sel2 = sel[1:0];
    logic [3:0] alu4 = alu[3:0];
    logic [1:0] pc2  = pc[1:0];
    return {s, w, sel2, alu4, pc2, g, 1'b0};
  endfunction

  function automatic logic [11:0] ref_ctrl(input logic [31:0] ins, input bit en_m);
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [11:0] ill = 12'h001;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) return pack(0, 1, 2, alu_r[f3], 0, 0);
        if (f7 == 7'h20 && f3 == 3'd0) return pack(0, 1, 2, 4, 0, 0);
        if (f7 == 7'h20 && f3 == 3'd5) return pack(0, 1, 2, 10, 0, 0);
        if (f7 == 7'h01 && en_m && alu_m[f3] >= 0) return pack(0, 1, 2, alu_m[f3], 0, 0);
        return ill;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? pack(1, 1, 2, 8, 0, 0) : ill;
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return pack(1, 1, 2, 9, 0, 0);
          if (f7 == 7'h20) return pack(1, 1, 2, 10, 0, 0);
          return ill;
        end
        return pack(1, 1, 2, alu_r[f3], 0, 0);
      end
      7'h37: return pack(0, 1, 1, 0, 0, 0);
      7'h6F: return pack(0, 1, 3, 0, 2, 0);
      7'h67: return (f3 == 3'd0) ? pack(1, 1, 3, 3, 3, 0) : ill;
      7'h63: return (alu_br[f3] >= 0) ? pack(0, 0, 0, alu_br[f3], 1, 0) : ill;
      7'h73: return (f3 == 3'd1 && ins[31:20] == 12'h7C0) ? pack(0, 1, 0, 0, 0, 1) : ill;
      default: return ill;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [2:0]  mf3[3] = '{3'd0, 3'd1, 3'd3};
    case ($urandom_range(0, 9))
      0, 8: begin w[6:0] = 7'h33; w[31:25] = f7s[$urandom_range(0, 3)]; end
      1: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
      end
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h6F;
      4: begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
      5: w[6:0] = 7'h63;
      6: begin
        w[6:0] = 7'h73;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'd1;
        if ($urandom_range(0, 3) != 0) w[31:20] = 12'h7C0;
      end
      9: begin w[6:0] = 7'h33; w[31:25] = 7'h01; w[14:12] = mf3[$urandom_range(0, 2)]; end
      default: ;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || act !== 12'h000 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: out_valid=%b ctrl=%h state=%b required 0/000/0", out_valid, act, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || act !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b ctrl=%h required 1/0/000", in_ready, out_valid, act);
    end
  endtask

  task automatic test_add();
    tick();
    instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_accept: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || act !== {1'b0, 1'b1, 2'd2, 4'd3, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_ctrl: out_valid=%b ctrl=%h required 1/%h", out_valid, act, 12'h630);
    end
    tick();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    tick();
    instr = 32'h4030D093; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first: in_ready=%b required 1", in_ready); end
    tick();
    instr = 32'h0030D093;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || aluop !== 4'd10 || alusrc !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_srai: in_ready=%b out_valid=%b aluop=%0d alusrc=%b required 1/1/10/1", in_ready, out_valid, aluop, alusrc);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || aluop !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_srli: out_valid=%b aluop=%0d required 1/9", out_valid, aluop);
    end
    tick();
  endtask

  task automatic test_mul();
    apply_reset();
    instr = 32'h022081B3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || aluop !== 4'd5 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_ctrl: out_valid=%b aluop=%0d illegal=%b required 1/5/0", out_valid, aluop, illegal);
    end
    n_checks++;
    if (m0_out_valid !== 1'b1 || m0_act !== 12'h001) begin
      n_fail++;
      $display("FAIL mul_nom_illegal: out_valid=%b ctrl=%h required 1/001", m0_out_valid, m0_act);
    end
    tick();
    instr = 32'h00108093; in_valid = 1'b1;
    for (int i = 0; i < MULC - 1; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || dbg_state !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_stall_%0d: in_ready=%b state=%b required 0/1", i, in_ready, dbg_state);
      end
      tick();
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_resume: in_ready=%b state=%b required 1/0", in_ready, dbg_state);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || act !== {1'b1, 1'b1, 2'd2, 4'd3, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_next_addi: out_valid=%b ctrl=%h required 1/%h", out_valid, act, 12'hE30);
    end
    tick();
  endtask

  task automatic test_csr();
    instr = 32'h7C009073; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    instr = 32'h7C109073;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || act !== {1'b0, 1'b1, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL csr_gpio: out_valid=%b ctrl=%h required 1/%h", out_valid, act, 12'h402);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || gpio_we !== 1'b0 || act !== 12'h001) begin
      n_fail++;
      $display("FAIL csr_other: ctrl=%h required 001", act);
    end
    tick();
  endtask

  task automatic test_hold();
    instr = 32'h000000EF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    instr = 32'h00108093;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || act !== {1'b0, 1'b1, 2'd3, 4'd0, 2'd2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b ctrl=%h required 1/0/%h", i, out_valid, in_ready, act, 12'h708);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || aluop !== 4'd3 || alusrc !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_followup: out_valid=%b aluop=%0d alusrc=%b required 1/3/1", out_valid, aluop, alusrc);
    end
    tick();
  endtask

  task automatic test_flush();
    instr = 32'h022081B3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00108093;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mulwait_in: in_ready=%b state=%b required 0/1", in_ready, dbg_state);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || act !== 12'h000 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mulwait_out: in_ready=%b out_valid=%b ctrl=%h required 1/0/000", in_ready, out_valid, act);
    end
    instr = 32'h000000EF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || act !== 12'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hold: out_valid=%b ctrl=%h in_ready=%b required 0/000/1", out_valid, act, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    instr = 32'h000000EF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || act !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_hold: out_valid=%b ctrl=%h required 0/000", out_valid, act);
    end
    tick();
    rst_n = 1'b1;
    instr = 32'h022081B3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_mulwait: state=%b out_valid=%b in_ready=%b required 0/0/1", dbg_state, out_valid, in_ready);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int stall_left;
    bit exp_rdy, fire_out, was_mul;
    logic [3:0] front_op;
    apply_reset();
    stall_left = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      instr     = rand_instr();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = (stall_left == 0) && (exp_q.size() == 0 || out_ready) && !flush;
      n_checks++;
      if (in_ready !== exp_rdy || out_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rand_flow c%0d: in_ready=%b out_valid=%b required %b/%b", cyc, in_ready, out_valid, exp_rdy, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (act !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_ctrl c%0d: ctrl=%h required %h", cyc, act, exp_q[0]);
        end
      end
      @(posedge clk);
      fire_out = (exp_q.size() != 0) && out_ready;
      front_op = (exp_q.size() != 0) ? exp_q[0][7:4] : 4'd0;
      if (flush) begin
        exp_q.delete();
        stall_left = 0;
      end else begin
        was_mul = fire_out && (front_op >= 4'd5) && (front_op <= 4'd7);
        if (stall_left > 0) stall_left--;
        else if (was_mul && MULC > 1) stall_left = MULC - 1;
        if (fire_out) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) exp_q.push_back(ref_ctrl(instr, 1'b1));
      end
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_csr();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
